fpu_div_seq: RTL and testbench

- Multi-cycle, parametrised IEEE-754 divider; successor to the single-cycle combinational FP divider.
- Radix-2 restoring mantissa division, one quotient bit per clock, instead of a full-width combinational divide.
- Adds RISC-V rounding modes, exception flags and valid/ready handshakes on input and output.
- Sits in the FPU next to the combinational add/mul units; the F-extension execute stage stalls on in_ready/out_valid.

---
 rtl/fpu_div_seq_if.sv | 26 ++
 rtl/fpu_div_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fpu_div_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_div_seq_if.sv
// Operand/result handshake bundle for the sequential FP divider.
// Latency: none, wires only.
// Backpressure: in_ready gates operand acceptance, out_ready holds the result.
interface fpu_div_seq_if #(
    parameter int BITS = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] x;
    logic [BITS-1:0] y;
    logic [2:0]      rm;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out;
    logic [4:0]      flags;

    modport master (
        output in_valid, x, y, rm, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, x, y, rm, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 divider: radix-2 restoring mantissa divide, RISC-V rounding and flags.
// Latency: MANTISSA_BITS+5 edges from accept for finite operands, 2 edges for special operands.
// Backpressure: one operation in flight; the result is held in DONE until out_ready is seen.
module fpu_div_seq #(
    parameter int BITS          = 32,
    parameter int MANTISSA_BITS = 23,
    parameter int EXPONENT_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    fpu_div_seq_if.slave bus
);
    localparam int M  = MANTISSA_BITS;
    localparam int E  = EXPONENT_BITS;
    localparam int EW = E + 2;
    localparam int LW = $clog2(M + 2);
    localparam int CW = $clog2(M + 3);

    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (E - 1)) - 1);
    localparam logic signed [EW-1:0] EXPMAX = EW'((1 << E) - 1);
    localparam logic signed [EW-1:0] EXPONE = EW'(1);
    localparam logic signed [EW-1:0] SHCAP  = EW'(M + 2);
    localparam logic [BITS-1:0]      QNAN   = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} stateT;

    stateT state, stateNext;

    logic inReady, outValid, accept, doUnpack, doDivide, doRound;

    logic [BITS-1:0] xReg, yReg;
    logic [2:0]      rmReg;
    logic [M+1:0]    rem;
    logic [M+2:0]    quo;
    logic [M:0]      dvsr;
    logic [CW-1:0]   cnt;
    logic signed [EW-1:0] expQ;
    logic            sgn;
    logic            isSpecial;
    logic [BITS-1:0] spRes;
    logic [4:0]      spFlags;
    logic [BITS-1:0] outReg;
    logic [4:0]      flagsReg;

    // Position of the leading one, counted from the hidden-bit position.
    function automatic logic [LW-1:0] lzCount(input logic [M:0] v);
        lzCount = '0;
        for (int i = 0; i <= M; i++) begin
            if (v[i]) lzCount = LW'(M - i);
        end
    endfunction

    // Operand fields.
    logic         xSign, ySign;
    logic [E-1:0] xExp, yExp;
    logic [M-1:0] xFrac, yFrac;

    assign xSign = xReg[BITS-1];
    assign ySign = yReg[BITS-1];
    assign xExp  = xReg[BITS-2:M];
    assign yExp  = yReg[BITS-2:M];
    assign xFrac = xReg[M-1:0];
    assign yFrac = yReg[M-1:0];

    logic xNan, yNan, xSnan, ySnan, xInf, yInf, xZero, yZero;

    assign xNan  = (&xExp) & (|xFrac);
    assign yNan  = (&yExp) & (|yFrac);
    assign xSnan = xNan & ~xFrac[M-1];
    assign ySnan = yNan & ~yFrac[M-1];
    assign xInf  = (&xExp) & ~(|xFrac);
    assign yInf  = (&yExp) & ~(|yFrac);
    assign xZero = ~(|xExp) & ~(|xFrac);
    assign yZero = ~(|yExp) & ~(|yFrac);

    // Normalise both mantissas so the divide always sees a leading one; denormals borrow exponent.
    logic [M:0]           xMant, yMant, xMantN, yMantN;
    logic [LW-1:0]        xLz, yLz;
    logic signed [EW-1:0] xExpN, yExpN, expTent;

    always_comb begin
        xMant   = {|xExp, xFrac};
        yMant   = {|yExp, yFrac};
        xLz     = lzCount(xMant);
        yLz     = lzCount(yMant);
        xMantN  = xMant << xLz;
        yMantN  = yMant << yLz;
        xExpN   = $signed({2'b00, (|xExp) ? xExp : E'(1)}) - $signed({{(EW-LW){1'b0}}, xLz});
        yExpN   = $signed({2'b00, (|yExp) ? yExp : E'(1)}) - $signed({{(EW-LW){1'b0}}, yLz});
        expTent = xExpN - yExpN + BIAS;
    end

    // Special-operand result, resolved in UNPACK so those operations skip the divide.
    logic            isSpecialNow;
    logic [BITS-1:0] spResNow;
    logic [4:0]      spFlagsNow;
    logic            qSign;

    assign qSign = xSign ^ ySign;

    always_comb begin
        isSpecialNow = 1'b1;
        spResNow     = '0;
        spFlagsNow   = '0;
        if (xNan || yNan) begin
            spResNow      = QNAN;
            spFlagsNow[4] = xSnan | ySnan;
        end else if ((xInf && yInf) || (xZero && yZero)) begin
            spResNow      = QNAN;
            spFlagsNow[4] = 1'b1;
        end else if (xInf) begin
            spResNow = {qSign, {E{1'b1}}, {M{1'b0}}};
        end else if (yZero) begin
            spResNow      = {qSign, {E{1'b1}}, {M{1'b0}}};
            spFlagsNow[3] = 1'b1;
        end else if (xZero || yInf) begin
            spResNow = {qSign, {(BITS-1){1'b0}}};
        end else begin
            isSpecialNow = 1'b0;
        end
    end

    // One restoring step: subtract the divisor when it fits, emit the quotient bit.
    logic [M+1:0] remDiff, remKeep;
    logic         remGe;

    assign remGe   = rem >= {1'b0, dvsr};
    assign remDiff = rem - {1'b0, dvsr};
    assign remKeep = remGe ? remDiff : rem;

    // Normalise, denormalise on underflow, round per rm and build the packed result and flags.
    logic                 qMsb, grd, stk, tiny, lost, grdR, stkR, lsb, inc, ovf, nx, toInf;
    logic [M:0]           sig;
    logic signed [EW-1:0] expR, shAmt;
    logic [M+1:0]         wide;
    logic [M:0]           wideSh;
    logic [E-1:0]         expField;
    logic [E+M-1:0]       sum;
    logic [BITS-1:0]      roundRes;
    logic [4:0]           roundFlags;

    always_comb begin
        qMsb  = quo[M+2];
        sig   = qMsb ? quo[M+2:2] : quo[M+1:1];
        grd   = qMsb ? quo[1] : quo[0];
        stk   = (qMsb & quo[0]) | (|rem);
        expR  = qMsb ? expQ : expQ - EXPONE;
        tiny  = expR < EXPONE;
        shAmt = '0;
        if (tiny) begin
            shAmt = EXPONE - expR;
            if (shAmt > SHCAP) shAmt = SHCAP;
        end
        wide     = {sig, grd};
        wideSh   = (M+1)'(wide >> shAmt);
        lost     = |(wide & ~({(M+2){1'b1}} << shAmt));
        grdR     = wideSh[0];
        stkR     = stk | lost;
        lsb      = wideSh[1];
        expField = tiny ? '0 : expR[E-1:0];

        case (rmReg)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn & (grdR | stkR);
            3'b011:  inc = ~sgn & (grdR | stkR);
            3'b100:  inc = grdR;
            default: inc = grdR & (stkR | lsb);
        endcase

        case (rmReg)
            3'b001:  toInf = 1'b0;
            3'b010:  toInf = sgn;
            3'b011:  toInf = ~sgn;
            default: toInf = 1'b1;
        endcase

        sum = {expField, wideSh[M:1]} + (E+M)'(inc);
        ovf = (~tiny && (expR >= EXPMAX)) || (&sum[E+M-1:M]);
        nx  = grdR | stkR;

        if (isSpecial) begin
            roundRes   = spRes;
            roundFlags = spFlags;
        end else if (ovf) begin
            roundRes   = toInf ? {sgn, {E{1'b1}}, {M{1'b0}}}
                               : {sgn, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
            roundFlags = 5'b00101;
        end else begin
            roundRes   = {sgn, sum};
            roundFlags = {3'b000, nx & ~(|sum[E+M-1:M]), nx};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic; specials go UNPACK -> ROUND -> DONE, bypassing the divide loop.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.in_valid) stateNext = UNPACK;
            UNPACK:  stateNext = isSpecialNow ? ROUND : DIVIDE;
            DIVIDE:  if (cnt == '0) stateNext = ROUND;
            ROUND:   stateNext = DONE;
            DONE:    if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Per-state handshake outputs and datapath enables.
    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        doUnpack = 1'b0;
        doDivide = 1'b0;
        doRound  = 1'b0;
        case (state)
            IDLE:    inReady  = 1'b1;
            UNPACK:  doUnpack = 1'b1;
            DIVIDE:  doDivide = 1'b1;
            ROUND:   doRound  = 1'b1;
            DONE:    outValid = 1'b1;
            default: ;
        endcase
    end

    assign accept        = bus.in_valid & inReady;
    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out       = outReg;
    assign bus.flags     = flagsReg;

    // Datapath registers: operand capture, unpack, divide iterations, result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xReg      <= '0;
            yReg      <= '0;
            rmReg     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            expQ      <= '0;
            sgn       <= 1'b0;
            isSpecial <= 1'b0;
            spRes     <= '0;
            spFlags   <= '0;
            outReg    <= '0;
            flagsReg  <= '0;
        end else begin
            if (accept) begin
                xReg  <= bus.x;
                yReg  <= bus.y;
                rmReg <= bus.rm;
            end
            if (doUnpack) begin
                rem       <= {1'b0, xMantN};
                dvsr      <= yMantN;
                quo       <= '0;
                cnt       <= CW'(M + 2);
                expQ      <= expTent;
                sgn       <= qSign;
                isSpecial <= isSpecialNow;
                spRes     <= spResNow;
                spFlags   <= spFlagsNow;
            end
            if (doDivide) begin
                rem <= {remKeep[M:0], 1'b0};
                quo <= {quo[M+1:0], remGe};
                cnt <= cnt - CW'(1);
            end
            if (doRound) begin
                outReg   <= roundRes;
                flagsReg <= roundFlags;
            end
        end
    end
endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed self-checking bench for fpu_div_seq with hand-computed vectors.
// Checks result, flags and accept-to-valid latency, plus backpressure and reset corners.
// Holds out_ready low until each result has been sampled.
module tb_fpu_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fpu_div_seq_if #(.BITS(32)) bus ();

    fpu_div_seq #(
        .BITS(32),
        .MANTISSA_BITS(23),
        .EXPONENT_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] expOut;
        logic [4:0]  expFlags;
        int          expLat;
    } vecT;

    localparam int NV = 24;
    vecT vecs [NV];

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s[%0d]: got 0x%08h, want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic startOp(input logic [31:0] xi, input logic [31:0] yi, input logic [2:0] rmi);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            nChecks++;
            nFail++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        bus.x        = xi;
        bus.y        = yi;
        bus.rm       = rmi;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = 32'hDEADBEEF;
        bus.y        = 32'h12345678;
        bus.rm       = 3'b001;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        //          x             y             rm     out           flags   lat
        vecs[0]  = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 28};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, 28};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01, 28};
        vecs[3]  = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'h01, 28};
        vecs[4]  = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'h01, 28};
        vecs[5]  = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'h01, 28};
        vecs[6]  = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 5'h01, 28};
        vecs[7]  = '{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 5'h01, 28};
        vecs[8]  = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08, 2};
        vecs[9]  = '{32'h00000000, 32'h80000000, 3'd0, 32'h7FC00000, 5'h10, 2};
        vecs[10] = '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10, 2};
        vecs[11] = '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00, 2};
        vecs[12] = '{32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'h10, 2};
        vecs[13] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'h00, 2};
        vecs[14] = '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'h00, 2};
        vecs[15] = '{32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 5'h00, 2};
        vecs[16] = '{32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'h05, 28};
        vecs[17] = '{32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'h05, 28};
        vecs[18] = '{32'h7F7FFFFF, 32'h3F000000, 3'd2, 32'h7F7FFFFF, 5'h05, 28};
        vecs[19] = '{32'hFF7FFFFF, 32'h3F000000, 3'd2, 32'hFF800000, 5'h05, 28};
        vecs[20] = '{32'h00800000, 32'h40000000, 3'd0, 32'h00400000, 5'h00, 28};
        vecs[21] = '{32'h00000003, 32'h40000000, 3'd0, 32'h00000002, 5'h03, 28};
        vecs[22] = '{32'h00000003, 32'h40000000, 3'd1, 32'h00000001, 5'h03, 28};
        vecs[23] = '{32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 5'h00, 28};

        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.rm        = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 0, {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", 0, {31'b0, bus.out_valid}, 32'd0);
        check("rst_out", 0, bus.out, 32'h0);
        check("rst_flags", 0, {27'b0, bus.flags}, 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            startOp(vecs[i].x, vecs[i].y, vecs[i].rm);
            waitResult(lat);
            check("latency", i, 32'(lat), 32'(vecs[i].expLat));
            check("out", i, bus.out, vecs[i].expOut);
            check("flags", i, {27'b0, bus.flags}, {27'b0, vecs[i].expFlags});
            releaseResult();
        end

        // Backpressure: result and flags held while out_ready stays low.
        startOp(32'h40C00000, 32'h40000000, 3'd0);
        waitResult(lat);
        check("bp_latency", 0, 32'(lat), 32'd28);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_out", c, bus.out, 32'h40400000);
            check("bp_flags", c, {27'b0, bus.flags}, 32'h0);
            check("bp_in_ready", c, {31'b0, bus.in_ready}, 32'd0);
            check("bp_out_valid", c, {31'b0, bus.out_valid}, 32'd1);
        end
        // New operand presented during the handshake cycle must wait for IDLE.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.x         = 32'h3F800000;
        bus.y         = 32'h40400000;
        bus.rm        = 3'd0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hs_in_ready", 0, {31'b0, bus.in_ready}, 32'd1);
        check("hs_out_valid", 0, {31'b0, bus.out_valid}, 32'd0);
        startOp(32'h3F800000, 32'h40400000, 3'd0);
        waitResult(lat);
        check("hs_latency", 0, 32'(lat), 32'd28);
        check("hs_out", 0, bus.out, 32'h3EAAAAAB);
        releaseResult();

        // Reset in the middle of DIVIDE discards the operation.
        startOp(32'h40C00000, 32'h40000000, 3'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 0, {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", 0, {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_out", 0, bus.out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_out_valid", 0, {31'b0, bus.out_valid}, 32'd0);
        check("post_rst_in_ready", 0, {31'b0, bus.in_ready}, 32'd1);

        // The next operation after reset completes normally.
        startOp(32'hBF800000, 32'h40400000, 3'd2);
        waitResult(lat);
        check("after_rst_latency", 0, 32'(lat), 32'd28);
        check("after_rst_out", 0, bus.out, 32'hBEAAAAAB);
        check("after_rst_flags", 0, {27'b0, bus.flags}, 32'h01);
        releaseResult();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end
endmodule
